// File: rtl/crc5_tgt_if.sv
// ---------------------------------------------------------------------------
// crc5_tgt_if -- bundle of the CRC5 target control/data signals.
//   i_crc_init        : 1-cycle seed reload pulse (DDR CCC controller -> CRC)
//   i_txtgt_crc_en    : 1-cycle byte strobe (target TX -> CRC)
//   i_txtgt_crc_data  : byte to fold, MSB first
//   o_crc_value       : running CRC5
//   o_crc_valid       : CRC covers every accepted byte since last init
//   o_crc_busy        : byte fold in progress
//   o_crc_overrun     : sticky dropped-strobe flag
// master = byte producer side, slave = the CRC block.
// ---------------------------------------------------------------------------
interface crc5_tgt_if;
  logic       i_crc_init;
  logic       i_txtgt_crc_en;
  logic [7:0] i_txtgt_crc_data;
  logic [4:0] o_crc_value;
  logic       o_crc_valid;
  logic       o_crc_busy;
  logic       o_crc_overrun;

  modport master (
    output i_crc_init, i_txtgt_crc_en, i_txtgt_crc_data,
    input  o_crc_value, o_crc_valid, o_crc_busy, o_crc_overrun
  );

  modport slave (
    input  i_crc_init, i_txtgt_crc_en, i_txtgt_crc_data,
    output o_crc_value, o_crc_valid, o_crc_busy, o_crc_overrun
  );
endinterface

// File: rtl/crc5_tgt.sv
// ---------------------------------------------------------------------------
// crc5_tgt -- running CRC5 (x^5+x^2+1, seed 5'b11111) over target TX bytes.
// Ports:
//   i_sys_clk : system clock, rising edge
//   i_sys_rst : asynchronous active-high reset
//   bus       : crc5_tgt_if.slave (init pulse, byte strobe/data, CRC value,
//               valid, busy, overrun)
// Build option CRC5_PARALLEL_EN:
//   undefined : serial IDLE/SHIFT datapath, one bit per clock, 8-cycle
//               latency, busy/overrun reporting.
//   defined   : whole byte folded in one clock, 1-cycle latency, busy and
//               overrun tied low, no FSM.
// ---------------------------------------------------------------------------
module crc5_tgt (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  crc5_tgt_if.slave  bus
);

  localparam int         DATA_W = 8;
  localparam logic [4:0] SEED   = 5'b11111;
  localparam logic [4:0] POLY   = 5'b00101;

  // Fold a single data bit into the CRC.
  function automatic logic [4:0] fold_bit(input logic [4:0] crc, input logic b);
    logic fb;
    fb = crc[4] ^ b;
    return {crc[3:0], 1'b0} ^ (fb ? POLY : 5'b00000);
  endfunction

  logic [4:0] val_q, val_d;
  logic       vld_q, vld_d;

`ifdef CRC5_PARALLEL_EN

  // Fold a whole byte, MSB first.
  function automatic logic [4:0] fold_byte(input logic [4:0] crc,
                                           input logic [DATA_W-1:0] d);
    logic [4:0] c;
    c = crc;
    for (int i = DATA_W - 1; i >= 0; i--) c = fold_bit(c, d[i]);
    return c;
  endfunction

  // Init applies before a same-cycle byte, so the byte starts from the seed.
  logic [4:0] base_val;
  assign base_val = bus.i_crc_init ? SEED : val_q;

  always_comb begin
    val_d = val_q;
    vld_d = vld_q;
    if (bus.i_crc_init) begin
      val_d = SEED;
      vld_d = 1'b0;
    end
    if (bus.i_txtgt_crc_en) begin
      val_d = fold_byte(base_val, bus.i_txtgt_crc_data);
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      val_q <= SEED;
      vld_q <= 1'b0;
    end else begin
      val_q <= val_d;
      vld_q <= vld_d;
    end
  end

  assign bus.o_crc_busy    = 1'b0;
  assign bus.o_crc_overrun = 1'b0;

`else

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [4:0]  work_q, work_d;
  logic        ovr_q, ovr_d;
  logic [4:0]  fold_nxt;

  assign fold_nxt = fold_bit(work_q, sh_q[DATA_W-1]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    work_d  = work_q;
    val_d   = val_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;
    if (bus.i_crc_init) begin
      // Abort any byte in flight and restart from the seed; a coincident
      // strobe is a legal first byte, not an overrun.
      state_d = IDLE;
      cnt_d   = 3'd0;
      val_d   = SEED;
      work_d  = SEED;
      vld_d   = 1'b0;
      ovr_d   = 1'b0;
      if (bus.i_txtgt_crc_en) begin
        state_d = SHIFT;
        sh_d    = bus.i_txtgt_crc_data;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_txtgt_crc_en) begin
            state_d = SHIFT;
            cnt_d   = 3'd0;
            sh_d    = bus.i_txtgt_crc_data;
            work_d  = val_q;
            vld_d   = 1'b0;
          end
        end
        SHIFT: begin
          work_d = fold_nxt;
          sh_d   = {sh_q[DATA_W-2:0], 1'b0};
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            val_d   = fold_nxt;
            vld_d   = 1'b1;
            state_d = IDLE;
            // A strobe on the final fold clock chains straight into the next
            // byte (1 byte / 8 clocks). work_d already holds the finished
            // CRC and the counter wraps to 0. Valid stays low because the
            // new byte is not yet covered.
            if (bus.i_txtgt_crc_en) begin
              state_d = SHIFT;
              sh_d    = bus.i_txtgt_crc_data;
              vld_d   = 1'b0;
            end
          end else if (bus.i_txtgt_crc_en) begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sh_q    <= '0;
      work_q  <= SEED;
      val_q   <= SEED;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      work_q  <= work_d;
      val_q   <= val_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.o_crc_busy    = (state_q == SHIFT);
  assign bus.o_crc_overrun = ovr_q;

`endif

  assign bus.o_crc_value = val_q;
  assign bus.o_crc_valid = vld_q;

endmodule
